// File: rtl/time_set_controller_if.sv
// Bundle of the time_set_controller's data and button signals.
// The master side (bench or surrounding clock logic) drives the live time and
// the button pulses. The slave side (the controller) drives the display feed
// and the load request toward the timekeeping counter.
interface time_set_controller_if;

  logic [23:0] time_bcd;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] display_data;
  logic [5:0]  display_digit_enable_mask;
  logic [23:0] set_time_bcd;
  logic        set_time_load;
  logic        set_mode;

  modport master (
    output time_bcd,
    output btn_mode,
    output btn_inc,
    input  display_data,
    input  display_digit_enable_mask,
    input  set_time_bcd,
    input  set_time_load,
    input  set_mode
  );

  modport slave (
    input  time_bcd,
    input  btn_mode,
    input  btn_inc,
    output display_data,
    output display_digit_enable_mask,
    output set_time_bcd,
    output set_time_load,
    output set_mode
  );

endinterface

// File: rtl/time_set_controller.sv
// time_set_controller: front end for led_display_driver in the 7-segment clock.
// RUN shows the live HH:MM:SS time. The SET_* states edit a captured copy one
// field at a time, blinking the selected field. Leaving SET_SECONDS issues a
// one-cycle load of the edited time toward the timekeeping counter.
//
// Optional build macro: SET_TIMEOUT_EN
//   When defined, set mode is abandoned (no load) after TIMEOUT_S seconds
//   without any button press. When undefined, set mode persists until the
//   user steps through to RUN with btn_mode.
//
// Every output is a register loaded from the next-state values, so a button
// pulse shows up on the outputs in the cycle right after the pulse.
module time_set_controller #(
  parameter int CLK_RATE_HZ = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int TIMEOUT_S   = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  time_set_controller_if.slave  bus
);

  // Blink half-period in clock cycles and the counter sized to hold it.
  localparam int HALF    = CLK_RATE_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);

  // Controller states.
  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_SET_HOURS   = 2'd1;
  localparam logic [1:0] ST_SET_MINUTES = 2'd2;
  localparam logic [1:0] ST_SET_SECONDS = 2'd3;

  logic [1:0]         r_state;
  logic [23:0]        r_edit;
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_blinkOn;
  logic [23:0]        r_displayData;
  logic [5:0]         r_mask;
  logic [23:0]        r_setTime;
  logic               r_load;
  logic               r_setMode;

  logic [1:0]         w_nextState;
  logic [23:0]        w_nextEdit;
  logic               w_loadNow;
  logic [BLINK_W-1:0] w_nextBlinkCnt;
  logic               w_nextBlinkOn;
  logic [5:0]         w_nextMask;
  logic [23:0]        w_nextDisplay;
  logic               w_timeoutExpire;

  // Hours step 00..23 and wrap; anything that is not valid BCD in that range
  // (low digit above 9, or 24 and up) restarts at 00.
  function automatic logic [7:0] incHours(input logic [7:0] h);
    logic [7:0] result;
    if ((h[3:0] > 4'd9) || (h >= 8'h23)) begin
      result = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      result = {h[7:4] + 4'd1, 4'd0};
    end else begin
      result = {h[7:4], h[3:0] + 4'd1};
    end
    return result;
  endfunction

  // Minutes step 00..59 and wrap; any invalid BCD value restarts at 00.
  function automatic logic [7:0] incMinutes(input logic [7:0] m);
    logic [7:0] result;
    if ((m[3:0] > 4'd9) || (m >= 8'h59)) begin
      result = 8'h00;
    end else if (m[3:0] == 4'd9) begin
      result = {m[7:4] + 4'd1, 4'd0};
    end else begin
      result = {m[7:4], m[3:0] + 4'd1};
    end
    return result;
  endfunction

`ifdef SET_TIMEOUT_EN
  // Inactivity limit in cycles; computed in 64 bits so large clock rates fit.
  localparam longint TIMEOUT_CYCLES = longint'(TIMEOUT_S) * longint'(CLK_RATE_HZ);
  localparam int     TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_idleCnt;

  assign w_timeoutExpire = (r_state != ST_RUN) && !bus.btn_mode && !bus.btn_inc
                           && (r_idleCnt == TO_LAST);

  // Count idle cycles in set mode; any button press or a return to RUN starts over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idleCnt <= '0;
    end else if ((w_nextState == ST_RUN) || bus.btn_mode || bus.btn_inc) begin
      r_idleCnt <= '0;
    end else begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end
`else
  assign w_timeoutExpire = 1'b0;

  // Without the timeout, TIMEOUT_S has no effect beyond a sanity guard.
  if (TIMEOUT_S < 0) begin : g_negativeTimeout
  end
`endif

  // Next state and next edit register; btn_mode always wins over btn_inc.
  always_comb begin
    w_nextState = r_state;
    w_nextEdit  = r_edit;
    w_loadNow   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.btn_mode) begin
          w_nextState = ST_SET_HOURS;
          w_nextEdit  = bus.time_bcd;
        end
      end
      ST_SET_HOURS: begin
        if (bus.btn_mode) begin
          w_nextState = ST_SET_MINUTES;
        end else if (bus.btn_inc) begin
          w_nextEdit[23:16] = incHours(r_edit[23:16]);
        end else if (w_timeoutExpire) begin
          w_nextState = ST_RUN;
        end
      end
      ST_SET_MINUTES: begin
        if (bus.btn_mode) begin
          w_nextState = ST_SET_SECONDS;
        end else if (bus.btn_inc) begin
          w_nextEdit[15:8] = incMinutes(r_edit[15:8]);
        end else if (w_timeoutExpire) begin
          w_nextState = ST_RUN;
        end
      end
      ST_SET_SECONDS: begin
        if (bus.btn_mode) begin
          w_nextState = ST_RUN;
          w_loadNow   = 1'b1;
        end else if (bus.btn_inc) begin
          w_nextEdit[7:0] = 8'h00;
        end else if (w_timeoutExpire) begin
          w_nextState = ST_RUN;
        end
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  // Blink timing: restart in the visible phase on entry to a field and on each increment.
  always_comb begin
    w_nextBlinkCnt = r_blinkCnt;
    w_nextBlinkOn  = r_blinkOn;
    if (w_nextState == ST_RUN) begin
      w_nextBlinkCnt = '0;
      w_nextBlinkOn  = 1'b1;
    end else if ((w_nextState != r_state) || bus.btn_inc) begin
      w_nextBlinkCnt = '0;
      w_nextBlinkOn  = 1'b1;
    end else if (r_blinkCnt == BLINK_LAST) begin
      w_nextBlinkCnt = '0;
      w_nextBlinkOn  = ~r_blinkOn;
    end else begin
      w_nextBlinkCnt = r_blinkCnt + 1'b1;
    end
  end

  // Digit mask and display word as they should look after this edge.
  always_comb begin
    w_nextMask    = 6'b111111;
    w_nextDisplay = w_nextEdit;
    if (w_nextState == ST_RUN) begin
      w_nextDisplay = bus.time_bcd;
    end else if (!w_nextBlinkOn) begin
      case (w_nextState)
        ST_SET_HOURS:   w_nextMask = 6'b001111;
        ST_SET_MINUTES: w_nextMask = 6'b110011;
        ST_SET_SECONDS: w_nextMask = 6'b111100;
        default:        w_nextMask = 6'b111111;
      endcase
    end
  end

  // Control state, edit copy and blink timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_edit     <= 24'h000000;
      r_blinkCnt <= '0;
      r_blinkOn  <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_edit     <= w_nextEdit;
      r_blinkCnt <= w_nextBlinkCnt;
      r_blinkOn  <= w_nextBlinkOn;
    end
  end

  // Output registers; the load pulse lines up with the first RUN display word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_displayData <= 24'h000000;
      r_mask        <= 6'b111111;
      r_setTime     <= 24'h000000;
      r_load        <= 1'b0;
      r_setMode     <= 1'b0;
    end else begin
      r_displayData <= w_nextDisplay;
      r_mask        <= w_nextMask;
      r_load        <= w_loadNow;
      r_setMode     <= (w_nextState != ST_RUN);
      if (w_loadNow) begin
        r_setTime <= r_edit;
      end
    end
  end

  assign bus.display_data              = r_displayData;
  assign bus.display_digit_enable_mask = r_mask;
  assign bus.set_time_bcd              = r_setTime;
  assign bus.set_time_load             = r_load;
  assign bus.set_mode                  = r_setMode;

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
Front-end controller for led_display_driver in the 7-segment clock. In run mode it passes the live HH:MM:SS time to the display driver. In set mode it edits a captured copy field by field and blinks the selected field through digit_enable_mask. On exit it emits a one-cycle load of the edited time toward the timekeeping counter.

Parameters:
CLK_RATE_HZ, 50000000, clock frequency in Hz, same meaning as in led_display_driver.
BLINK_HZ, 2, blink rate of the selected field; half-period HALF = CLK_RATE_HZ/(2*BLINK_HZ) cycles.
TIMEOUT_S, 30, set-mode inactivity timeout in seconds; used only with SET_TIMEOUT_EN.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
time_bcd  input  24  live time, packed BCD HH MM SS; [23:20] is the hours tens digit.
btn_mode  input  1  one-cycle pulse, already debounced: enter set mode / next field / exit.
btn_inc  input  1  one-cycle pulse, already debounced: increment the selected field.
display_data  output  24  feeds led_display_driver data.
display_digit_enable_mask  output  6  feeds led_display_driver digit_enable_mask; bit 5 = digit [23:20], bit 0 = digit [3:0].
set_time_bcd  output  24  edited time, valid while set_time_load is high.
set_time_load  output  1  one-cycle pulse requesting the counter to load set_time_bcd.
set_mode  output  1  high in any SET_* state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=RUN, edit register=0, blink phase=on, blink counter=0, set_time_load=0, set_time_bcd=0, set_mode=0.
- All outputs are registered: a state change appears on outputs one cycle after the triggering pulse.
- States: RUN, SET_HOURS, SET_MINUTES, SET_SECONDS.
- RUN:
  - display_data = time_bcd (registered, 1-cycle latency); mask = 6'b111111.
  - btn_mode -> capture time_bcd into the edit register, go to SET_HOURS.
  - btn_inc is ignored.
- SET_* states:
  - display_data = edit register.
  - Mask = 111111, except the selected pair is cleared during the off phase: hours = bits 5:4, minutes = bits 3:2, seconds = bits 1:0.
  - btn_mode advances SET_HOURS -> SET_MINUTES -> SET_SECONDS -> RUN.
  - On SET_SECONDS -> RUN: set_time_bcd = edit register and set_time_load=1 for exactly one cycle. The pulse appears in the same cycle as the first RUN output.
- Increment rules (BCD):
  - Hours: 00..23, 23 -> 00.
  - Minutes: 00..59, 59 -> 00.
  - Seconds: any btn_inc sets 00.
  - A field holding an invalid BCD value (e.g. hours 2F or 24+, a digit > 9) becomes 00 on increment.
  - Other fields are unchanged.
- Blink:
  - Counter counts 0..HALF-1; phase toggles on wrap.
  - Counter clears and phase forces to on when entering any SET_* state and on every btn_inc. The selected field therefore stays visible while it is being edited.
  - Counter is held at 0 in RUN.
- Simultaneous btn_mode and btn_inc: mode wins, inc is dropped.
- Reset mid-edit: the edit is discarded and no load pulse is generated.
- time_bcd changes during set mode do not affect the edit register.

Optional Feature:
SET_TIMEOUT_EN
- Defined:
  - An inactivity counter of TIMEOUT_S*CLK_RATE_HZ cycles runs in SET_* states and clears on any btn_mode or btn_inc.
  - On expiry the block returns to RUN with no set_time_load; the edit is discarded.
  - Counter width is sized from the product.
- Undefined: no counter; set mode persists until the user exits via btn_mode.

Test Plan:
1. Run pass-through, CLK_RATE_HZ=16, BLINK_HZ=2 (HALF=4): reset, then time_bcd=24'h12_34_56 -> display_data=123456, mask=111111, set_mode=0, set_time_load never asserted.
2. Enter set: btn_mode with time_bcd=24'h23_59_58, then btn_inc -> edit hours=00, display_data=005958. Mask bits 5:4 toggle every 4 cycles, starting on for 4 cycles after the inc.
3. Minutes wrap: from step 2, btn_mode then btn_inc -> display_data=000058; btn_mode, btn_inc -> 000000.
4. Exit and load: btn_mode in SET_SECONDS with edit=24'h00_00_00 -> set_time_load high exactly 1 cycle with set_time_bcd=000000, then state RUN and mask=111111.
5. Simultaneous pulse and invalid field: btn_mode with btn_inc in SET_HOURS -> state SET_MINUTES, fields unchanged. Separately, captured hours=8'h2F, btn_inc -> hours=00.
6. Reset and timeout: async reset asserted mid-SET_MINUTES -> immediately RUN, no load pulse. With SET_TIMEOUT_EN, TIMEOUT_S=1, CLK_RATE_HZ=16: 16 idle cycles in set mode -> RUN, set_time_load stays 0.
